// File: rtl/echo_processor.sv
// Echo/comb-filter stage between ADC and DAC: offset removal, delayed attenuated
// subtraction from a circular buffer (feed-forward or feedback), saturation, DAC re-offset.
module echo_processor #(
    parameter int unsigned       DATA_W     = 10,
    parameter int unsigned       ADDR_W     = 13,
    parameter logic [DATA_W-1:0] ADC_OFFSET = 10'h181,
    parameter logic [DATA_W-1:0] DAC_OFFSET = 10'h200
) (
    input  logic              sysclk,
    input  logic              rst,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] delay,
    input  logic [2:0]        shift,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    output logic              sat,
    output logic              overrun
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic              r_dv;
    logic              r_armed;
    logic              r_v1, r_v2, r_v3;
    logic [DATA_W-1:0] r_x;
    logic [1:0]        r_mode;
    logic [ADDR_W-1:0] r_delay;
    logic [2:0]        r_shift;
    logic [DATA_W-1:0] r_rd_data;
    logic [DATA_W-1:0] r_e;
    logic [DATA_W-1:0] r_y;
    logic              r_clamp;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_fill;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_strobe;
    logic              w_busy;
    logic              w_accept;
    logic [ADDR_W-1:0] w_rd_addr;
    logic              w_ff;
    logic              w_fb;
    logic              w_echo_en;
    logic [DATA_W-1:0] w_e;
    logic [DATA_W:0]   w_diff;
    logic              w_ovf;
    logic [DATA_W-1:0] w_y;
    logic              w_wr_en;
    logic [DATA_W-1:0] w_wr_data;

    // r_armed blocks a level already high at reset release from counting as an edge
    assign w_strobe  = data_valid & ~r_dv & r_armed;
    assign w_busy    = r_v1 | r_v2 | r_v3;
    assign w_accept  = w_strobe & ~w_busy;
    assign w_rd_addr = r_wr_ptr - delay;

    assign w_ff      = (r_mode == 2'b01);
    assign w_fb      = (r_mode == 2'b10);
    assign w_echo_en = (w_ff | w_fb) && (r_delay != '0) && (r_fill >= r_delay);

    always_comb begin
        w_e = '0;
        if (w_echo_en) begin
            w_e = $signed(r_rd_data) >>> r_shift;
        end
    end

    assign w_diff = {r_x[DATA_W-1], r_x} - {r_e[DATA_W-1], r_e};
    assign w_ovf  = w_diff[DATA_W] ^ w_diff[DATA_W-1];

    always_comb begin
        w_y = w_diff[DATA_W-1:0];
        if (w_ovf) begin
            w_y = w_diff[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end

    assign w_wr_en   = r_v2 & (w_ff | w_fb);
    assign w_wr_data = w_fb ? w_y : r_x;

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            r_dv      <= 1'b0;
            r_armed   <= 1'b0;
            r_v1      <= 1'b0;
            r_v2      <= 1'b0;
            r_v3      <= 1'b0;
            r_x       <= '0;
            r_mode    <= '0;
            r_delay   <= '0;
            r_shift   <= '0;
            r_e       <= '0;
            r_y       <= '0;
            r_clamp   <= 1'b0;
            r_wr_ptr  <= '0;
            r_fill    <= '0;
            data_out  <= DAC_OFFSET;
            out_valid <= 1'b0;
            sat       <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            r_dv    <= data_valid;
            r_armed <= r_armed | ~data_valid;
            r_v1    <= w_accept;
            r_v2    <= r_v1;
            r_v3    <= r_v2;
            if (w_strobe && w_busy) begin
                overrun <= 1'b1;
            end
            if (w_accept) begin
                r_x     <= data_in - ADC_OFFSET;
                r_mode  <= mode;
                r_delay <= delay;
                r_shift <= shift;
            end
            if (r_v1) begin
                r_e <= w_e;
            end
            if (r_v2) begin
                r_y     <= w_y;
                r_clamp <= w_ovf;
                if (w_wr_en) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                    if (r_fill != '1) begin
                        r_fill <= r_fill + 1'b1;
                    end
                end
            end
            out_valid <= r_v3;
            if (r_v3) begin
                data_out <= r_y + DAC_OFFSET;
                sat      <= r_clamp;
            end
        end
    end

    // Buffer RAM is never cleared; the fill gate keeps unwritten words out of the result
    always_ff @(posedge sysclk) begin
        if (w_accept) begin
            r_rd_data <= r_mem[w_rd_addr];
        end
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_wr_data;
        end
    end

endmodule

// File: tb/tb_echo_processor.sv
// Scoreboard bench for echo_processor: stimulus pushes expected DAC words, a monitor
// pops and compares on every out_valid.
module tb_echo_processor;

    logic        sysclk;
    logic        rst;
    logic        data_valid;
    logic [9:0]  data_in;
    logic [1:0]  mode;
    logic [12:0] delay;
    logic [2:0]  shift;
    logic [9:0]  data_out;
    logic        out_valid;
    logic        sat;
    logic        overrun;

    typedef struct packed {
        logic [9:0] d;
        logic       s;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    echo_processor dut (
        .sysclk    (sysclk),
        .rst       (rst),
        .data_valid(data_valid),
        .data_in   (data_in),
        .mode      (mode),
        .delay     (delay),
        .shift     (shift),
        .data_out  (data_out),
        .out_valid (out_valid),
        .sat       (sat),
        .overrun   (overrun)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every out_valid must match the oldest pending expectation
    always @(negedge sysclk) begin
        if (!rst && out_valid) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_out_valid: got data_out 0x%0h, expected no output",
                         data_out);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("data_out", {22'd0, data_out}, {22'd0, e.d});
                chk("sat", {31'd0, sat}, {31'd0, e.s});
            end
        end
    end

    task automatic reset_dut(input logic dv_high);
        @(negedge sysclk);
        rst        = 1'b1;
        data_valid = dv_high;
        repeat (2) @(negedge sysclk);
        rst = 1'b0;
        repeat (4) @(negedge sysclk);
        data_valid = 1'b0;
        repeat (2) @(negedge sysclk);
    endtask

    task automatic send(input logic [9:0] din, input logic [1:0] m, input logic [12:0] d,
                        input logic [2:0] sh, input logic [9:0] exp_d, input logic exp_s);
        q.push_back('{d: exp_d, s: exp_s});
        data_in    = din;
        mode       = m;
        delay      = d;
        shift      = sh;
        data_valid = 1'b1;
        @(negedge sysclk);
        data_valid = 1'b0;
        repeat (5) @(negedge sysclk);
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (q.size() != 0 && i < 20) begin
            @(negedge sysclk);
            i++;
        end
        chk("queue_drained", q.size(), 0);
    endtask

    initial begin
        rst        = 1'b1;
        data_valid = 1'b0;
        data_in    = 10'h181;
        mode       = 2'b00;
        delay      = '0;
        shift      = '0;
        repeat (2) @(negedge sysclk);
        chk("reset_data_out", {22'd0, data_out}, 32'h200);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_sat", {31'd0, sat}, 32'd0);
        chk("reset_overrun", {31'd0, overrun}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge sysclk);

        // Bypass
        send(10'h281, 2'b00, 13'd0, 3'd0, 10'h300, 1'b0);
        drain();

        // Feed-forward impulse
        reset_dut(1'b0);
        send(10'h281, 2'b01, 13'd3, 3'd1, 10'h300, 1'b0);
        send(10'h181, 2'b01, 13'd3, 3'd1, 10'h200, 1'b0);
        send(10'h181, 2'b01, 13'd3, 3'd1, 10'h200, 1'b0);
        send(10'h181, 2'b01, 13'd3, 3'd1, 10'h180, 1'b0);
        send(10'h181, 2'b01, 13'd3, 3'd1, 10'h200, 1'b0);
        drain();

        // Feedback decay
        reset_dut(1'b0);
        send(10'h281, 2'b10, 13'd2, 3'd1, 10'h300, 1'b0);
        send(10'h181, 2'b10, 13'd2, 3'd1, 10'h200, 1'b0);
        send(10'h181, 2'b10, 13'd2, 3'd1, 10'h180, 1'b0);
        send(10'h181, 2'b10, 13'd2, 3'd1, 10'h200, 1'b0);
        send(10'h181, 2'b10, 13'd2, 3'd1, 10'h240, 1'b0);
        send(10'h181, 2'b10, 13'd2, 3'd1, 10'h200, 1'b0);
        send(10'h181, 2'b10, 13'd2, 3'd1, 10'h1E0, 1'b0);
        drain();

        // data_valid held high across reset release: no strobe
        data_in = 10'h281;
        mode    = 2'b00;
        reset_dut(1'b1);
        chk("no_strobe_at_release", {31'd0, out_valid}, 32'd0);

        // Saturation
        send(10'h381, 2'b01, 13'd1, 3'd0, 10'h000, 1'b0);
        send(10'h380, 2'b01, 13'd1, 3'd0, 10'h3FF, 1'b1);
        send(10'h181, 2'b01, 13'd1, 3'd0, 10'h001, 1'b0);
        drain();

        // Fill gate then overrun
        reset_dut(1'b0);
        send(10'h281, 2'b01, 13'd5, 3'd0, 10'h300, 1'b0);
        send(10'h281, 2'b01, 13'd5, 3'd0, 10'h300, 1'b0);
        send(10'h281, 2'b01, 13'd5, 3'd0, 10'h300, 1'b0);
        chk("overrun_before", {31'd0, overrun}, 32'd0);
        q.push_back('{d: 10'h300, s: 1'b0});
        data_valid = 1'b1;
        @(negedge sysclk);
        data_valid = 1'b0;
        @(negedge sysclk);
        data_in    = 10'h181;
        data_valid = 1'b1;
        @(negedge sysclk);
        data_valid = 1'b0;
        chk("overrun_set", {31'd0, overrun}, 32'd1);
        repeat (8) @(negedge sysclk);
        drain();
        chk("overrun_sticky", {31'd0, overrun}, 32'd1);

        // Reset mid-pipeline
        data_in    = 10'h281;
        mode       = 2'b01;
        data_valid = 1'b1;
        @(negedge sysclk);
        data_valid = 1'b0;
        rst        = 1'b1;
        repeat (2) @(negedge sysclk);
        rst = 1'b0;
        repeat (8) @(negedge sysclk);
        chk("midrst_data_out", {22'd0, data_out}, 32'h200);
        chk("midrst_sat", {31'd0, sat}, 32'd0);
        chk("midrst_overrun", {31'd0, overrun}, 32'd0);
        chk("midrst_wr_ptr", {19'd0, dut.r_wr_ptr}, 32'd0);
        chk("midrst_fill", {19'd0, dut.r_fill}, 32'd0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
